pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the RV32IM 5-stage pipeline (IF, ID, EX, MA, WB). It drives the hold and bubble controls of the PC and of the IF_ID, ID_EX, EX_MA and MA_WB pipeline registers. It resolves four hazard sources:
- load-use,
- taken branch/jump,
- multi-cycle data-memory access,
- fixed-latency M-extension divide.

It also counts stall cycles for performance monitoring.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/div_latency_counter.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: sequencer state encoding,
// the x0 register index and the divide-latency counter width.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    localparam logic [4:0] REG_X0    = 5'd0;
    localparam int         DIV_CNT_W = 8;

endpackage

// File: rtl/div_latency_counter.sv
// Down-counter tracking the remaining EX occupancy of a divide.
// Loads on load_i, steps down on dec_i, holds its value otherwise.
module div_latency_counter
    import cpu_ctrl_pkg::*;
#(
    parameter logic [DIV_CNT_W-1:0] LOAD_VAL = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 dec_i,
    output logic [DIV_CNT_W-1:0] cnt_o,
    output logic                 last_o
);

    localparam logic [DIV_CNT_W-1:0] ONE = DIV_CNT_W'(1);

    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle data-memory access and fixed-latency divide, plus a stall-cycle counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; single-cycle hazards resolved combinationally
//   DIV_WAIT | divide occupying EX, front end and EX/MA held
//   MEM_WAIT | data memory busy, everything up to EX/MA held, bubble to WB
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        ex_div_start,
    input  logic        ma_mem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_ma_stall,
    output logic        ma_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_ma_flush,
    output logic        ma_wb_flush,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_LATENCY - 1);

    hazard_state_e state_q, state_d;
    hazard_state_e saved_q, saved_d;
    hazard_state_e eff_state;

    logic [31:0]          stall_q, stall_d;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 div_last;
    logic                 cnt_load, cnt_dec;
    logic                 load_use;

    logic pc_s, if_id_s, id_ex_s, ex_ma_s, ma_wb_s;
    logic if_id_f, id_ex_f, ex_ma_f, ma_wb_f;
    logic done_c;

    div_latency_counter #(
        .LOAD_VAL (DIV_LOAD)
    ) u_div_cnt (
        .clk_i   (CLK),
        .rst_n_i (RESET),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .cnt_o   (div_cnt),
        .last_o  (div_last)
    );

    assign load_use = ex_memread && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Once busy drops, behave as the interrupted state in that same cycle so
    // MEM_WAIT costs exactly the busy cycles.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        pc_s     = 1'b0;
        if_id_s  = 1'b0;
        id_ex_s  = 1'b0;
        ex_ma_s  = 1'b0;
        ma_wb_s  = 1'b0;
        if_id_f  = 1'b0;
        id_ex_f  = 1'b0;
        ex_ma_f  = 1'b0;
        ma_wb_f  = 1'b0;
        done_c   = 1'b0;

        if (ma_mem_busy) begin
            pc_s    = 1'b1;
            if_id_s = 1'b1;
            id_ex_s = 1'b1;
            ex_ma_s = 1'b1;
            ma_wb_f = 1'b1;
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else if (eff_state == DIV_WAIT) begin
            pc_s    = 1'b1;
            if_id_s = 1'b1;
            id_ex_s = 1'b1;
            ex_ma_s = 1'b1;
            cnt_dec = 1'b1;
            state_d = DIV_WAIT;
            if (div_last) begin
                done_c  = 1'b1;
                ex_ma_s = 1'b0;
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
            if (ex_div_start) begin
                pc_s     = 1'b1;
                if_id_s  = 1'b1;
                id_ex_s  = 1'b1;
                ex_ma_s  = 1'b1;
                cnt_load = 1'b1;
                state_d  = DIV_WAIT;
            end else if (ex_branch_taken) begin
                if_id_f = 1'b1;
                id_ex_f = 1'b1;
            end else if (load_use) begin
                pc_s    = 1'b1;
                if_id_s = 1'b1;
                id_ex_f = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (pc_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= RUN;
            saved_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            stall_q <= stall_d;
        end
    end

    // Reset forces bubbles everywhere; a flush always overrides a stall on the same register.
    assign if_id_flush  = !RESET || if_id_f;
    assign id_ex_flush  = !RESET || id_ex_f;
    assign ex_ma_flush  = !RESET || ex_ma_f;
    assign ma_wb_flush  = !RESET || ma_wb_f;
    assign pc_stall     = RESET && pc_s;
    assign if_id_stall  = RESET && if_id_s && !if_id_flush;
    assign id_ex_stall  = RESET && id_ex_s && !id_ex_flush;
    assign ex_ma_stall  = RESET && ex_ma_s && !ex_ma_flush;
    assign ma_wb_stall  = RESET && ma_wb_s && !ma_wb_flush;
    assign div_done     = RESET && done_c;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    // {pc, if_id_s, id_ex_s, ex_ma_s, ma_wb_s, if_id_f, id_ex_f, ex_ma_f, ma_wb_f, div_done}
    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_RST   = 10'b0000011110;
    localparam logic [9:0] V_LU    = 10'b1100001000;
    localparam logic [9:0] V_BR    = 10'b0000011000;
    localparam logic [9:0] V_DIV   = 10'b1111000000;
    localparam logic [9:0] V_DONE  = 10'b1110000001;
    localparam logic [9:0] V_BUSY  = 10'b1111000010;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, ex_div_start, ma_mem_busy;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_ma_stall, ma_wb_stall;
    logic        if_id_flush, id_ex_flush, ex_ma_flush, ma_wb_flush, div_done;
    logic [31:0] stall_cycles;

    pipeline_hazard_ctrl #(.DIV_LATENCY(LAT)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_div_start    (ex_div_start),
        .ma_mem_busy     (ma_mem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_ma_stall     (ex_ma_stall),
        .ma_wb_stall     (ma_wb_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_ma_flush     (ex_ma_flush),
        .ma_wb_flush     (ma_wb_flush),
        .div_done        (div_done),
        .stall_cycles    (stall_cycles)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          m_rem;       // EX cycles the current divide still needs (0: none in flight)
    logic [31:0] m_cnt;
    logic [9:0]  m_vec;

    function automatic logic [9:0] dut_vec();
        return {pc_stall, if_id_stall, id_ex_stall, ex_ma_stall, ma_wb_stall,
                if_id_flush, id_ex_flush, ex_ma_flush, ma_wb_flush, div_done};
    endfunction

    task automatic chk_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: stall_cycles got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_out();
        logic       hit;
        logic [9:0] v;
        hit = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        v = V_IDLE;
        if (!RESET)                          v = V_RST;
        else if (ma_mem_busy)                v = V_BUSY;
        else if (m_rem == 1)                 v = V_DONE;
        else if (m_rem > 1 || ex_div_start)  v = V_DIV;
        else if (ex_branch_taken)            v = V_BR;
        else if (hit)                        v = V_LU;
        return v;
    endfunction

    task automatic model_reset();
        m_rem = 0;
        m_cnt = 32'd0;
    endtask

    task automatic model_advance();
        if (!RESET) begin
            model_reset();
        end else begin
            if (m_vec[9] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (!ma_mem_busy) begin
                if (m_rem > 0)         m_rem = m_rem - 1;
                else if (ex_div_start) m_rem = LAT - 1;
            end
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic mr,
                         input logic br, input logic ds, input logic bz);
        id_rs1 = r1;  id_rs2 = r2;  ex_rd = rd;
        id_use_rs1 = u1;  id_use_rs2 = u2;  ex_memread = mr;
        ex_branch_taken = br;  ex_div_start = ds;  ma_mem_busy = bz;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are set at the falling edge; outputs compared 1 ns later, model steps at the rising edge.
    task automatic cycle(input bit lit_en, input logic [9:0] lit);
        #1;
        m_vec = model_out();
        chk_vec("model_vec", dut_vec(), m_vec);
        chk_cnt("model_count", stall_cycles, m_cnt);
        if (lit_en) chk_vec("literal_vec", dut_vec(), lit);
        @(posedge CLK);
        model_advance();
        @(negedge CLK);
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge CLK);
        cycle(1, V_RST);
        cycle(1, V_RST);
        RESET = 1'b1;
        chk_cnt("reset_count", stall_cycles, 32'd0);

        // load-use through rs2
        drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1, V_LU);
        idle();
        chk_cnt("lu_count", stall_cycles, 32'd1);
        cycle(1, V_IDLE);
        // load into x0 never interlocks
        drive(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1, V_IDLE);
        // rs1 matches but is not read
        drive(5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1, V_IDLE);
        // taken branch beats load-use
        drive(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1, V_BR);
        idle();
        chk_cnt("branch_count", stall_cycles, 32'd1);

        // plain divide
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1, V_DIV);
        idle();
        cycle(1, V_DIV);
        cycle(1, V_DIV);
        cycle(1, V_DONE);
        cycle(1, V_IDLE);
        chk_cnt("div_count", stall_cycles, 32'd5);

        // divide interrupted by a 3-cycle memory wait in its second cycle
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1, V_DIV);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1, V_BUSY);
        idle();
        cycle(1, V_DIV);
        cycle(1, V_DIV);
        cycle(1, V_DONE);
        cycle(1, V_IDLE);
        chk_cnt("div_mem_count", stall_cycles, 32'd12);

        // reset in the middle of a divide
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1, V_DIV);
        idle();
        cycle(1, V_DIV);
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        chk_vec("async_reset_vec", dut_vec(), V_RST);
        chk_cnt("async_reset_count", stall_cycles, 32'd0);
        @(posedge CLK);
        model_advance();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (6) cycle(1, V_IDLE);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(99) != 0);
            if (!RESET) model_reset();
            drive(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(9) < 3), ($urandom_range(19) < 3),
                  ($urandom_range(19) == 0), ($urandom_range(19) < 3));
            cycle(0, V_IDLE);
        end
        RESET = 1'b1;
        idle();
        repeat (LAT + 2) cycle(0, V_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
